// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared debounce state encoding and default qualification length
package input_conditioner_pkg;
  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF = 3;
endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: 2-flop synchroniser plus debounce FSM giving a clean level and change pulse
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_b,
  input  logic raw,
  output logic level,
  output logic edge_pulse
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, diff, done, level_n, edge_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  state_t state, state_n;
  // synchronise the asynchronous raw input before any decision is made on it
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) {sync1, sync2} <= 2'b00;
    else {sync1, sync2} <= {raw, sync1};
  // FSM, counter and registered outputs
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= STABLE;
      cnt <= '0;
      level <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      level <= level_n;
      edge_pulse <= edge_n;
    end
  // any return to the current level restarts qualification; the last differing clock commits the update
  always_comb begin
    diff = sync2 != level;
    done = state == STABLE ? DEBOUNCE_CYCLES == 1 : cnt == LAST;
    state_n = diff && !done ? CHECK : STABLE;
    cnt_n = !diff || done ? '0 : state == STABLE ? CNT_W'(1) : cnt + 1'b1;
    level_n = diff && done ? sync2 : level;
    edge_n = diff && done;
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: two independent debounced channels producing in_x/in_y for the sequence detector
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_b,
  input  logic raw_x,
  input  logic raw_y,
  output logic out_x,
  output logic out_y,
  output logic x_edge,
  output logic y_edge
);
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_x (
    .clk(clk), .reset_b(reset_b), .raw(raw_x), .level(out_x), .edge_pulse(x_edge)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_y (
    .clk(clk), .reset_b(reset_b), .raw(raw_y), .level(out_y), .edge_pulse(y_edge)
  );
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table-driven and sequence checks of the input conditioner
module tb_input_conditioner;
  logic clk = 1'b0, reset_b, raw_x, raw_y, out_x, out_y, x_edge, y_edge;
  int checks = 0, errors = 0;
  typedef struct {logic [1:0] r; logic [3:0] e;} vec_t;
  vec_t tv[$];

  input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset_b(reset_b), .raw_x(raw_x), .raw_y(raw_y),
    .out_x(out_x), .out_y(out_y), .x_edge(x_edge), .y_edge(y_edge)
  );

  always #5 clk = ~clk;

  function automatic void add(int n, logic [1:0] r, logic [3:0] e);
    for (int i = 0; i < n; i++) tv.push_back('{r, e});
  endfunction

  task automatic check(string nm, logic [3:0] e);
    logic [3:0] got;
    got = {out_x, out_y, x_edge, y_edge};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got {out_x,out_y,x_edge,y_edge}=%b expected %b", nm, got, e);
    end
  endtask

  task automatic step(string nm, logic [1:0] r, logic [3:0] e);
    {raw_x, raw_y} = r;
    @(posedge clk);
    #1 check(nm, e);
    @(negedge clk);
  endtask

  initial begin
    // rows: {raw_x,raw_y} applied before the edge, {out_x,out_y,x_edge,y_edge} expected after it
    add(5, 2'b11, 4'b0000);
    add(1, 2'b11, 4'b1111);
    add(1, 2'b11, 4'b1100);
    add(5, 2'b01, 4'b1100);
    add(1, 2'b01, 4'b0110);
    add(1, 2'b01, 4'b0100);
    add(3, 2'b11, 4'b0100);
    add(8, 2'b01, 4'b0100);
    add(1, 2'b11, 4'b0100);
    add(1, 2'b01, 4'b0100);
    add(1, 2'b11, 4'b0100);
    add(1, 2'b01, 4'b0100);
    add(5, 2'b11, 4'b0100);
    add(1, 2'b11, 4'b1110);
    add(1, 2'b11, 4'b1100);
    add(5, 2'b00, 4'b1100);
    add(1, 2'b00, 4'b0011);
    add(1, 2'b00, 4'b0000);
    add(5, 2'b11, 4'b0000);
    add(1, 2'b11, 4'b1111);
    add(1, 2'b11, 4'b1100);
    reset_b = 1'b0;
    {raw_x, raw_y} = 2'b11;
    #1 check("reset_t0", 4'b0000);
    for (int i = 0; i < 3; i++) step($sformatf("reset_hold%0d", i), 2'b11, 4'b0000);
    reset_b = 1'b1;
    for (int i = 0; i < tv.size(); i++) step($sformatf("vec%0d", i + 1), tv[i].r, tv[i].e);
    reset_b = 1'b0;
    #1 check("async_reset", 4'b0000);
    {raw_x, raw_y} = 2'b00;
    @(negedge clk);
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("idle%0d", i), 2'b00, 4'b0000);
    for (int i = 0; i < 3; i++) step($sformatf("pre_reset%0d", i), 2'b10, 4'b0000);
    reset_b = 1'b0;
    #1 check("mid_reset", 4'b0000);
    for (int i = 0; i < 2; i++) step($sformatf("mid_hold%0d", i), 2'b10, 4'b0000);
    reset_b = 1'b1;
    for (int i = 0; i < 5; i++) step($sformatf("requal%0d", i + 1), 2'b10, 4'b0000);
    step("requal6", 2'b10, 4'b1010);
    step("requal7", 2'b10, 4'b1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that feeds the two-input sequence-detector FSM. It produces that FSM's in_x and in_y from raw, asynchronous switch or button inputs.
- Each raw input passes through a 2-flop synchroniser and then a per-channel debounce state machine. The output is a clean, glitch-free level plus a one-cycle change pulse.
- Both channels are independent and identical.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clocks the synchronised input must differ from the current output before the output follows. Legal range ≥1.
- CNT_W, 3: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset_b  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- raw_x  input  1  unsynchronised raw input for channel X.
- raw_y  input  1  unsynchronised raw input for channel Y.
- out_x  output  1  debounced level of raw_x; drives the downstream FSM's in_x.
- out_y  output  1  debounced level of raw_y; drives the downstream FSM's in_y.
- x_edge  output  1  one-cycle pulse, high in the cycle out_x changes value.
- y_edge  output  1  one-cycle pulse, high in the cycle out_y changes value.

Behaviour:
- Reset (reset_b low, asynchronous) sets:
  - sync flops = 0
  - counters = 0
  - FSM = STABLE
  - out_x = out_y = 0
  - x_edge = y_edge = 0
- All outputs are registered; there is no combinational path from raw inputs to any output.
- Synchroniser, per channel: sync1 <= raw and sync2 <= sync1 on each posedge. The debounce logic sees only sync2.
- Debounce FSM per channel, two states:
  - STABLE: if sync2 == level, hold and keep cnt = 0. If sync2 != level and DEBOUNCE_CYCLES == 1, take the update action below on this edge. Otherwise go to CHECK with cnt <= 1.
  - CHECK: if sync2 == level, the glitch is rejected; go to STABLE with cnt <= 0 and level unchanged. If sync2 != level and cnt == DEBOUNCE_CYCLES-1, take the update action. Otherwise cnt <= cnt+1 and stay in CHECK.
  - Update action: level <= sync2, edge <= 1, cnt <= 0, state <= STABLE.
- edge is high for exactly one cycle and cleared on the next posedge.
- Latency: a raw change first sampled at posedge k appears on the output after posedge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges. With the default, that is 6 edges.
- Any return of sync2 to the current level restarts the qualification from zero. There is no partial credit across bounces.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around occurs.
- Channels are fully independent. Simultaneous changes on raw_x and raw_y produce simultaneous output and edge changes.
- Reset mid-CHECK abandons the qualification. After release, a still-changed input needs the full latency again.
- Reset does not require clk to be running.

Decomposition:
- Shared constants file: FSM state encodings STABLE = 1'b0 and CHECK = 1'b1, plus the default DEBOUNCE_CYCLES.
- One sub-module, debounce_channel (synchroniser + counter + FSM; ports clk, reset_b, raw, level, edge), instantiated twice.
- Top level is wiring plus parameter pass-through only.

Test Plan:
- Reset behaviour: hold reset_b low with raw_x = raw_y = 1 → all outputs 0 throughout. Release → out_x = out_y = 1 after the 6th posedge; x_edge and y_edge high for exactly that cycle.
- Glitch rejection: from reset state, raw_x = 1 for 3 clocks, then 0 → out_x stays 0 and x_edge never asserts.
- Falling change: with out_x = 1, drop raw_x to 0 and hold → out_x = 0 after the 6th posedge; single-cycle x_edge; out_y unaffected.
- Bounce: raw_x toggles 1, 0, 1, 0, 1 on consecutive edges, then holds 1 → out_x rises exactly 6 edges after the last transition; only one x_edge pulse.
- Simultaneous change: raw_x and raw_y both go 0→1 on the same edge → out_x and out_y rise on the same posedge; x_edge and y_edge coincide.
- Reset mid-operation: raw_x 0→1, assert reset_b after 3 edges for 2 cycles, keep raw_x = 1 → outputs 0 immediately on assertion; out_x rises 6 edges after release.
